// File: rtl/demux_pkg.sv
// Shared constants and FSM state type for the 1-to-4 stream demultiplexer.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry registered holding slot for a single output channel.
module demux_out_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             d_last,
  input  logic             ready_in,
  output logic             valid,
  output logic [WIDTH-1:0] q,
  output logic             q_last,
  output logic             can_load
);

  // A full slot may accept a new beat only when it is draining this cycle.
  assign can_load = !valid || ready_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      q      <= '0;
      q_last <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      q      <= d;
      q_last <= d_last;
    end else if (valid && ready_in) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1in_4out_stream.sv
// Routes packets from one valid/ready stream to one of four channels; the
// select is captured on the first beat and held until the last beat.
module demux_1in_4out_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [SEL_W-1:0]      in_sel,
  output logic                  in_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]     out_valid,
  output logic [NUM_CH-1:0]     out_last,
  input  logic [NUM_CH-1:0]     out_ready,
  output logic                  sel_err
);

  state_t           state_reg, state_next;
  logic [SEL_W-1:0] cur_sel_reg, cur_sel_next;
  logic             sel_err_reg, sel_err_next;
  logic [SEL_W-1:0] target;
  logic [NUM_CH-1:0] can_load;
  logic [NUM_CH-1:0] load;
  logic             transfer;

  // in_ready depends on in_sel/out_ready but deliberately never on in_valid.
  assign target   = (state_reg == IDLE) ? in_sel : cur_sel_reg;
  assign in_ready = rst_n && can_load[target];
  assign transfer = in_valid && in_ready;
  assign sel_err  = sel_err_reg;

  always_comb begin
    state_next   = state_reg;
    cur_sel_next = cur_sel_reg;
    sel_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (transfer && !in_last) begin
          state_next   = BUSY;
          cur_sel_next = in_sel;
        end
      end
      BUSY: begin
        sel_err_next = in_valid && (in_sel != cur_sel_reg);
        if (transfer && in_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cur_sel_reg <= '0;
      sel_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cur_sel_reg <= cur_sel_next;
      sel_err_reg <= sel_err_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
      assign load[gi] = transfer && (target == SEL_W'(gi));

      demux_out_slot #(
        .WIDTH(WIDTH)
      ) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load[gi]),
        .d        (in_data),
        .d_last   (in_last),
        .ready_in (out_ready[gi]),
        .valid    (out_valid[gi]),
        .q        (out_data[gi*WIDTH +: WIDTH]),
        .q_last   (out_last[gi]),
        .can_load (can_load[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_demux_1in_4out_stream.sv
// Scoreboard bench for the 1-to-4 stream demultiplexer.
module tb_demux_1in_4out_stream;

  localparam int WIDTH = 8;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         c;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic [1:0]       in_sel;
  logic             in_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_last;
  logic [3:0]       out_ready;
  logic             sel_err;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   sel_err_cnt = 0;
  bit   lat_chk = 1'b0;
  exp_t exp_q[4][$];

  demux_1in_4out_stream #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_sel    (in_sel),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Output monitor: every drained beat must match the head of its channel queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sel_err) sel_err_cnt++;
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            check($sformatf("ch%0d_unexpected", k), {24'h0, out_data[k*8 +: 8]}, 32'hFFFF_FFFF);
          end else begin
            exp_t e;
            e = exp_q[k].pop_front();
            check($sformatf("ch%0d_data", k), {24'h0, out_data[k*8 +: 8]}, {24'h0, e.d});
            check($sformatf("ch%0d_last", k), {31'h0, out_last[k]}, {31'h0, e.l});
            if (lat_chk) check($sformatf("ch%0d_latency", k), cyc - e.c, 1);
          end
        end
      end
    end
  end

  // Drives one beat until accepted; inputs stay driven on return.
  task automatic send(input logic [7:0] d, input logic l, input logic [1:0] s,
                      input int ch, output int waits);
    exp_t e;
    in_data  = d;
    in_last  = l;
    in_sel   = s;
    in_valid = 1'b1;
    waits    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e.d = d; e.l = l; e.c = cyc;
        exp_q[ch].push_back(e);
        @(posedge clk); #1;
        break;
      end
      waits++;
      if (waits > 50) begin
        check("send_timeout", waits, 0);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int w;
    int base;
    int stalls;
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; in_sel = '0;
    out_ready = 4'b0000;
    #3;
    check("rst_in_ready", {31'h0, in_ready}, 0);
    check("rst_out_valid", {28'h0, out_valid}, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sel_err", {31'h0, sel_err}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 4'b1111;
    idle_cycles(2);

    // 1: single-beat packet to channel 2
    send(8'hA5, 1'b1, 2'd2, 2, w);
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_out_valid", {28'h0, out_valid}, 32'h4);
    check("t1_data", {24'h0, out_data[23:16]}, 32'hA5);
    check("t1_last", {31'h0, out_last[2]}, 1);
    @(posedge clk); #1;
    idle_cycles(1);

    // 2: 3-beat packet; select changes mid-packet but routing holds
    base = sel_err_cnt;
    send(8'h11, 1'b0, 2'd1, 1, w);
    send(8'h22, 1'b0, 2'd3, 1, w);
    send(8'h33, 1'b1, 2'd3, 1, w);
    idle_cycles(3);
    check("t2_sel_err_pulses", sel_err_cnt - base, 2);

    // 3: backpressure on channel 0
    out_ready = 4'b1110;
    send(8'hC1, 1'b0, 2'd0, 0, w);
    in_data = 8'hC2; in_last = 1'b0; in_sel = 2'd0; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t3_in_ready_stall", {31'h0, in_ready}, 0);
      check("t3_data_stable", {24'h0, out_data[7:0]}, 32'hC1);
    end
    @(posedge clk); #1;
    out_ready = 4'b1111;
    send(8'hC2, 1'b0, 2'd0, 0, w);
    send(8'hC3, 1'b1, 2'd0, 0, w);
    idle_cycles(3);
    check("t3_ch0_drained", exp_q[0].size(), 0);

    // 4: stalled channel 3 does not block channel 2
    out_ready = 4'b0111;
    send(8'hD3, 1'b1, 2'd3, 3, w);
    send(8'hE2, 1'b1, 2'd2, 2, w);
    check("t4_ch2_no_stall", w, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("t4_ch3_held", {24'h0, out_data[31:24]}, 32'hD3);
    check("t4_ch3_valid", {31'h0, out_valid[3]}, 1);
    check("t4_ch2_data", {24'h0, out_data[23:16]}, 32'hE2);
    @(posedge clk); #1;
    out_ready = 4'b1111;
    idle_cycles(3);

    // 5: reset in the middle of a 4-beat packet
    send(8'h51, 1'b0, 2'd1, 1, w);
    send(8'h52, 1'b0, 2'd1, 1, w);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_async_clear", {28'h0, out_valid}, 0);
    check("t5_in_ready_rst", {31'h0, in_ready}, 0);
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'h5A, 1'b1, 2'd0, 0, w);
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_resample_ch0", {28'h0, out_valid}, 32'h1);
    check("t5_data", {24'h0, out_data[7:0]}, 32'h5A);
    @(posedge clk); #1;
    idle_cycles(2);

    // 6: 16 back-to-back beats to channel 1 at full rate
    base = sel_err_cnt;
    stalls = 0;
    lat_chk = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(8'(8'h80 + i), (i == 15), 2'd1, 1, w);
      stalls += w;
    end
    idle_cycles(3);
    lat_chk = 1'b0;
    check("t6_no_stalls", stalls, 0);
    check("t6_no_sel_err", sel_err_cnt - base, 0);

    for (int k = 0; k < 4; k++) check($sformatf("final_q%0d_empty", k), exp_q[k].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1in_4out_stream.md
Name: demux_1in_4out_stream

Overview:
- Stream-side inverse of the 4-input, 1-output mux.
- Takes one valid/ready input stream and routes each packet to one of four output channels, chosen by a 2-bit select.
- The select is latched on the first beat of a packet and held until the last beat.
- Each output channel has a one-entry registered holding slot, so channels drain independently and a stalled channel blocks only packets aimed at it.

Parameters:
- WIDTH, 8, data width of each beat.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  input beat data.
- in_valid  input  1  input beat present.
- in_last  input  1  final beat of the packet.
- in_sel  input  2  destination channel, 0..3; sampled on the first beat only.
- in_ready  output  1  input beat accepted this cycle when in_valid is also high.
- out_data  output  4*WIDTH  channel k data at bits [k*WIDTH +: WIDTH].
- out_valid  output  4  per-channel valid.
- out_last  output  4  per-channel last flag.
- out_ready  input  4  per-channel downstream ready.
- sel_err  output  1  one-cycle pulse: in_sel differed from the latched select mid-packet.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - On rst_n low, asynchronously: state=IDLE, cur_sel=0, out_valid=0, out_data=0, out_last=0, sel_err=0.
  - in_ready is combinational and also reads 0 during reset.
- Target channel: t = (state==IDLE) ? in_sel : cur_sel.
- in_ready = !out_valid[t] || out_ready[t].
  - This is a combinational path from out_ready and in_sel. It is allowed and documented.
  - The path from in_valid to in_ready must stay combinationally independent.
- Transfer occurs when in_valid && in_ready.
  - On a transfer, slot t loads in_data/in_last and out_valid[t]=1 next cycle.
  - Latency is 1 cycle from input acceptance to out_valid.
- Slot drain:
  - out_valid[k] && out_ready[k] empties slot k, unless it reloads in the same cycle.
  - A simultaneous drain and load keeps out_valid[k]=1 with the new data, giving full throughput of 1 beat/cycle per channel.
  - Channels that are not targeted drain independently of the input.
- FSM states:
  - IDLE: waiting for the first beat of a packet.
  - BUSY: mid-packet, routed to cur_sel.
- FSM transitions:
  - IDLE, transfer with in_last=0 -> BUSY, cur_sel<=in_sel.
  - IDLE, transfer with in_last=1 -> stays IDLE (single-beat packet); cur_sel unchanged.
  - BUSY, transfer with in_last=1 -> IDLE.
  - BUSY, transfer with in_last=0 -> stays BUSY.
  - No transfer -> state holds.
- Select error:
  - In BUSY, when in_valid=1 and in_sel!=cur_sel, sel_err=1 on the next cycle for one cycle.
  - Data is still routed to cur_sel.
  - This holds whether or not the beat transferred; repeated cycles give repeated pulses.
- Stalls:
  - Output data is never overwritten while out_valid[k]=1 && out_ready[k]=0.
  - The input stalls (in_ready=0) instead.
- Reset mid-packet:
  - The packet is abandoned and all slots are cleared.
  - The first beat after reset is treated as a new packet (IDLE).
- in_sel is a full 2-bit decode; there are no illegal values.

Decomposition:
- Shared package demux_pkg:
  - NUM_CH=4, SEL_W=2.
  - State typedef with IDLE, BUSY.
- Sub-module demux_out_slot (WIDTH):
  - One-entry holding register with load/drain handshake.
  - Ports: clk, rst_n, load, d, d_last, ready_in, valid, q, q_last, can_load.
  - Instantiated 4 times by generate loop.
- The top level holds the FSM, cur_sel, target mux, in_ready and sel_err.

Test Plan:
1. Single-beat packet: reset, out_ready=4'b1111, in_sel=2, in_data=8'hA5, in_last=1, 1 cycle valid -> out_valid=4'b0100 next cycle, out_data[23:16]=A5, out_last[2]=1; FSM stays IDLE.
2. 3-beat packet 11,22,33 with in_sel=1 on beat 1 and in_sel=3 on beats 2-3 -> all beats appear on channel 1 in order; sel_err pulses twice; IDLE after beat 3.
3. Backpressure: packet to ch0 with out_ready[0]=0 -> first beat held in slot, in_ready=0, out_data[7:0] stable; raise out_ready[0] -> one beat/cycle thereafter, no loss or duplication.
4. Independent channels: ch3 slot full and stalled, new packet to ch2 -> in_ready=1, ch2 receives data, ch3 data unchanged.
5. Reset mid-packet: assert rst_n=0 after beat 2 of 4 -> out_valid=0 immediately (async); after release, a beat with in_sel=0 routes to ch0 (IDLE resampling).
6. Throughput: 16 back-to-back beats to ch1 with out_ready[1]=1 -> in_ready never drops; output beats on consecutive cycles, 1-cycle latency.
